key_scan_ctrl: RTL and testbench

- Time-multiplexed debounce controller for a bank of NKEYS push-buttons.
- One shared up/down hysteresis engine is sequenced across all keys on a periodic sample tick. Per-key counters are held in a small register array.
- Produces per-key level and toggle outputs, plus a press/release event FIFO with valid/ready for the CPU-side IO register block.
- Sits between the raw GPIO button pins and the IO bus slave.

---
 rtl/key_scan_ctrl_if.sv | 35 +++
 rtl/key_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_key_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/key_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// key_scan_ctrl_if
//   Event-FIFO read port of the key scan controller: a head-of-queue event
//   code qualified by a valid flag, and a ready strobe that pops it.
//
//   Signals
//     evt_valid  producer -> consumer  event FIFO non-empty
//     evt_code   producer -> consumer  head event {edge, key index}
//     evt_ready  consumer -> producer  pop strobe (ignored while empty)
//
//   Modports
//     master  the controller that owns the FIFO
//     slave   the CPU-side register block that drains it
// -----------------------------------------------------------------------------
interface key_scan_ctrl_if #(
  parameter int CODE_W = 4
);

  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic              evt_ready;

  modport master (
    output evt_valid,
    output evt_code,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    output evt_ready
  );

endinterface

// File: rtl/key_scan_ctrl.sv
// -----------------------------------------------------------------------------
// key_scan_ctrl
//   Time-multiplexed debounce controller for a bank of NKEYS push-buttons.
//   A single up/down saturating hysteresis engine is stepped across all keys,
//   one key per clock, after every prescaler tick. Press/release edges are
//   queued in a small event FIFO that the CPU-side register block drains.
//
//   Ports
//     clk         system clock
//     rst         asynchronous reset, active low (0 = reset)
//     keys_in     raw asynchronous key levels, 1 = pressed
//     mode        per key: 1 = toggle mode, 0 = momentary
//     level_out   debounced key state
//     toggle_out  toggle state (follows level_out for momentary keys)
//     evt         event FIFO read port (valid / code / ready)
//     evt_ovf     sticky: an event was dropped because the FIFO was full
//     ovf_clr     clears evt_ovf (a new drop in the same cycle wins)
// -----------------------------------------------------------------------------
module key_scan_ctrl #(
  parameter int NKEYS      = 8,
  parameter int TICK_DIV   = 1024,
  parameter int CNT_MAX    = 7,
  parameter int PRESS_TH   = 6,
  parameter int RELEASE_TH = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] keys_in,
  input  logic [NKEYS-1:0] mode,
  output logic [NKEYS-1:0] level_out,
  output logic [NKEYS-1:0] toggle_out,
  key_scan_ctrl_if.master  evt,
  output logic             evt_ovf,
  input  logic             ovf_clr
);

  localparam int IW = $clog2(NKEYS);       // key index width
  localparam int EW = IW + 1;              // event code width {edge, index}
  localparam int CW = $clog2(CNT_MAX + 1); // per-key counter width
  localparam int PW = $clog2(TICK_DIV);    // prescaler width
  localparam int AW = $clog2(FIFO_DEPTH);  // FIFO address width

  // ---------------------------------------------------------------------------
  // Input synchronizer: two flops per key, scan only ever reads sync2_q.
  // ---------------------------------------------------------------------------
  logic [NKEYS-1:0] sync1_q;
  logic [NKEYS-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= keys_in;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample-tick prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          tick;

  always_comb begin
    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan sequencer: IDLE waits for a tick, SCAN visits keys 0..NKEYS-1.
  // ---------------------------------------------------------------------------
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic          scan_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (idx_q == IW'(NKEYS - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    scan_en = (state_q == SCAN);
  end

  // ---------------------------------------------------------------------------
  // Per-key state: hysteresis counters, debounced level, toggle.
  // ---------------------------------------------------------------------------
  logic [CW-1:0]    cnt_q [NKEYS];
  logic [NKEYS-1:0] level_q;
  logic [NKEYS-1:0] toggle_q;

  // Shared engine operating on the key selected by idx_q.
  logic          cur_k;
  logic [CW-1:0] cur_c;
  logic          cur_lvl;
  logic          cur_tog;
  logic          cur_mode;
  logic [CW-1:0] cnt_d;
  logic          lvl_d;
  logic          tog_d;
  logic          press_evt;
  logic          rel_evt;
  logic          push;
  logic [EW-1:0] push_code;

  always_comb begin
    cur_k    = sync2_q[idx_q];
    cur_c    = cnt_q[idx_q];
    cur_lvl  = level_q[idx_q];
    cur_tog  = toggle_q[idx_q];
    cur_mode = mode[idx_q];

    // Saturating step in both directions.
    if (cur_k) begin
      cnt_d = (cur_c == CW'(CNT_MAX)) ? cur_c : cur_c + CW'(1);
    end else begin
      cnt_d = (cur_c == '0) ? cur_c : cur_c - CW'(1);
    end

    // Hysteresis on the updated count: the band between the two thresholds
    // holds the previous level.
    lvl_d     = cur_lvl;
    press_evt = 1'b0;
    rel_evt   = 1'b0;
    if (!cur_lvl && (cnt_d >= CW'(PRESS_TH))) begin
      lvl_d     = 1'b1;
      press_evt = 1'b1;
    end else if (cur_lvl && (cnt_d < CW'(RELEASE_TH))) begin
      lvl_d   = 1'b0;
      rel_evt = 1'b1;
    end

    // Toggle keys flip only on a press; momentary keys mirror the level.
    tog_d = cur_mode ? (cur_tog ^ press_evt) : lvl_d;

    push      = scan_en && (press_evt || rel_evt);
    push_code = {press_evt, idx_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NKEYS; i++) begin
        cnt_q[i] <= '0;
      end
      level_q  <= '0;
      toggle_q <= '0;
    end else if (scan_en) begin
      cnt_q[idx_q]    <= cnt_d;
      level_q[idx_q]  <= lvl_d;
      toggle_q[idx_q] <= tog_d;
    end
  end

  assign level_out  = level_q;
  assign toggle_out = toggle_q;

  // ---------------------------------------------------------------------------
  // Event FIFO. Pointers carry one extra wrap bit so full and empty differ.
  // ---------------------------------------------------------------------------
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          wr_en;
  logic          drop;
  logic          ovf_q;

  always_comb begin
    fifo_cnt   = wr_ptr_q - rd_ptr_q;
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (fifo_cnt == (AW + 1)'(FIFO_DEPTH));
    pop        = !fifo_empty && evt.evt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    wr_en      = push && (!fifo_full || pop);
    drop       = push && fifo_full && !pop;
  end

  // When full with a concurrent pop, the write slot equals the head slot; the
  // head is read combinationally this cycle and overwritten at the edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= push_code;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_code  = fifo_empty ? '0 : fifo_mem[rd_ptr_q[AW-1:0]];
  assign evt_ovf       = ovf_q;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_scan_ctrl
//   Directed bench for key_scan_ctrl (NKEYS=4, TICK_DIV=8, FIFO_DEPTH=4).
//   Stimulus pushes the expected event codes into a queue; an independent
//   monitor pops and compares whenever the DUT hands over an event.
//   After each reset the bench sits on a "tick boundary": every key of the
//   most recent tick has been scanned, and the next scan is 5 edges away.
// -----------------------------------------------------------------------------
module tb_key_scan_ctrl;

  localparam int NK  = 4;
  localparam int TD  = 8;
  localparam int FD  = 4;
  localparam int CWD = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK-1:0] keys_in = '0;
  logic [NK-1:0] mode = '0;
  logic [NK-1:0] level_out;
  logic [NK-1:0] toggle_out;
  logic          evt_ovf;
  logic          ovf_clr = 1'b0;

  key_scan_ctrl_if #(.CODE_W(CWD)) evt_bus ();

  key_scan_ctrl #(
    .NKEYS     (NK),
    .TICK_DIV  (TD),
    .CNT_MAX   (7),
    .PRESS_TH  (6),
    .RELEASE_TH(2),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .keys_in   (keys_in),
    .mode      (mode),
    .level_out (level_out),
    .toggle_out(toggle_out),
    .evt       (evt_bus),
    .evt_ovf   (evt_ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CWD-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  // Scoreboard monitor: every handed-over event must match the queue head.
  always @(negedge clk) begin
    if (rst && evt_bus.evt_valid && evt_bus.evt_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL evt_unexpected: got %0h expected none", evt_bus.evt_code);
      end else begin
        check("evt_code", 32'(evt_bus.evt_code), 32'(exp_q.pop_front()));
      end
    end
  end

  // Advance n sample ticks, ending 1 time unit after a boundary edge.
  task automatic ticks(input int n);
    repeat (n * TD) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [NK-1:0] k, input logic [NK-1:0] md,
                          input logic rdy, input logic chk);
    rst               = 1'b0;
    keys_in           = k;
    mode              = md;
    evt_bus.evt_ready = rdy;
    ovf_clr           = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    if (chk) begin
      check("rst_level", 32'(level_out), 32'h0);
      check("rst_toggle", 32'(toggle_out), 32'h0);
      check("rst_valid", 32'(evt_bus.evt_valid), 32'h0);
      check("rst_code", 32'(evt_bus.evt_code), 32'h0);
      check("rst_ovf", 32'(evt_ovf), 32'h0);
    end
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Let the monitor drain what is pending, then require nothing outstanding.
  task automatic end_check(input string name);
    repeat (3) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'h0);
    #1;
  endtask

  initial begin
    evt_bus.evt_ready = 1'b1;

    // ---- Reset and first clean press of all keys ----
    do_reset(4'hF, 4'h0, 1'b1, 1'b1);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b101);
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b111);
    ticks(5);
    check("pre6_level", 32'(level_out), 32'h0);
    check("pre6_valid", 32'(evt_bus.evt_valid), 32'h0);
    ticks(1);
    check("tick6_level", 32'(level_out), 32'hF);
    check("tick6_toggle", 32'(toggle_out), 32'hF);
    end_check("rst_events_done");

    // ---- Bounce rejection on key 1 ----
    do_reset(4'h0, 4'h0, 1'b1, 1'b0);
    for (int t = 0; t < 20; t++) begin
      keys_in[1] = (t % 2 == 0);
      ticks(1);
      check("bounce_level", 32'(level_out), 32'h0);
    end
    end_check("bounce_events_done");

    // ---- Hysteresis release on key 2 ----
    do_reset(4'h0, 4'h0, 1'b1, 1'b0);
    keys_in = 4'b0100;
    exp_q.push_back(3'b110);
    ticks(7);
    check("hyst_pressed", 32'(level_out), 32'b0100);
    keys_in = 4'b0000;
    exp_q.push_back(3'b010);
    ticks(5);
    check("hyst_hold5", 32'(level_out), 32'b0100);
    ticks(1);
    check("hyst_rel6", 32'(level_out), 32'b0000);
    end_check("hyst_events_done");

    // ---- Toggle mode on key 0 ----
    do_reset(4'h0, 4'b0001, 1'b1, 1'b0);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b000);
    keys_in = 4'b0001;
    ticks(5);
    check("tog_pre_toggle", 32'(toggle_out), 32'h0);
    ticks(1);
    check("tog_p1_level", 32'(level_out), 32'h1);
    check("tog_p1_toggle", 32'(toggle_out), 32'h1);
    ticks(1);
    keys_in = 4'b0000;
    ticks(6);
    check("tog_r1_level", 32'(level_out), 32'h0);
    check("tog_r1_toggle", 32'(toggle_out), 32'h1);
    ticks(1);
    keys_in = 4'b0001;
    ticks(6);
    check("tog_p2_level", 32'(level_out), 32'h1);
    check("tog_p2_toggle", 32'(toggle_out), 32'h0);
    ticks(1);
    keys_in = 4'b0000;
    ticks(6);
    check("tog_r2_level", 32'(level_out), 32'h0);
    check("tog_r2_toggle", 32'(toggle_out), 32'h0);
    end_check("tog_events_done");

    // ---- Overflow: 5 events into a 4-deep FIFO with no consumer ----
    do_reset(4'h0, 4'h0, 1'b0, 1'b0);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b101);
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b111);
    keys_in = 4'hF;
    ticks(6);
    check("ovf_full_valid", 32'(evt_bus.evt_valid), 32'h1);
    check("ovf_not_yet", 32'(evt_ovf), 32'h0);
    check("ovf_head", 32'(evt_bus.evt_code), 32'b100);
    keys_in = 4'b1110;
    ticks(5);
    check("ovf_set", 32'(evt_ovf), 32'h1);
    check("ovf_head_stable", 32'(evt_bus.evt_code), 32'b100);
    evt_bus.evt_ready = 1'b1;
    ovf_clr           = 1'b1;
    @(posedge clk);
    #1;
    evt_bus.evt_ready = 1'b0;
    ovf_clr           = 1'b0;
    check("ovf_cleared", 32'(evt_ovf), 32'h0);
    evt_bus.evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ovf_one_left", 32'(evt_bus.evt_valid), 32'h1);
    @(posedge clk);
    #1;
    evt_bus.evt_ready = 1'b0;
    check("ovf_drained", 32'(evt_bus.evt_valid), 32'h0);
    end_check("ovf_events_done");

    // ---- Full FIFO with a pop in the same cycle as a new event ----
    do_reset(4'h0, 4'h0, 1'b0, 1'b0);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b101);
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b111);
    keys_in = 4'hF;
    ticks(6);
    keys_in = 4'b1110;
    ticks(4);
    exp_q.push_back(3'b000);
    // Key 0 releases on the next tick, at the first scan edge (5 edges away).
    repeat (4) @(posedge clk);
    #1;
    evt_bus.evt_ready = 1'b1;
    @(posedge clk);
    #1;
    evt_bus.evt_ready = 1'b0;
    check("fp_no_ovf", 32'(evt_ovf), 32'h0);
    check("fp_valid", 32'(evt_bus.evt_valid), 32'h1);
    evt_bus.evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("fp_four_held", 32'(evt_bus.evt_valid), 32'h1);
    @(posedge clk);
    #1;
    evt_bus.evt_ready = 1'b0;
    check("fp_drained", 32'(evt_bus.evt_valid), 32'h0);
    end_check("fp_events_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
